// File: rtl/draw_missile_pool_pkg.sv
// Shared types, widths and colours for the missile pool renderer.
// Optional halo feature: MISSILE_POOL_GLOW_EN (adds GLOW_COLOR ring drawing).
package draw_missile_pool_pkg;

   localparam int CNT_W = 11;   // VGA hcount/vcount width
   localparam int RGB_W = 12;   // 4:4:4 pixel width

   typedef logic [CNT_W-1:0] vga_cnt_t;
   typedef logic [RGB_W-1:0] rgb_t;

   // One cycle's worth of VGA timing, carried through the output register.
   typedef struct packed {
      vga_cnt_t hcount;
      logic     hsync;
      logic     hblnk;
      vga_cnt_t vcount;
      logic     vsync;
      logic     vblnk;
   } vga_timing_t;

   localparam rgb_t MISSILE_COLOR = 12'hDD3;
`ifdef MISSILE_POOL_GLOW_EN
   localparam rgb_t GLOW_COLOR    = 12'h862;
`endif

   // True when pos lies in [base - margin, base + len - 1 + margin].
   // Evaluated in 12 bits so a rectangle touching column/row 2047 cannot
   // wrap around and light up the opposite screen edge.
   function automatic logic span_hit(input vga_cnt_t    pos,
                                     input vga_cnt_t    base,
                                     input int unsigned len,
                                     input logic        margin);
      logic [CNT_W:0] pos_w;
      logic [CNT_W:0] lo_w;
      logic [CNT_W:0] hi_w;
      pos_w = {1'b0, pos};
      lo_w  = {1'b0, base};
      hi_w  = {1'b0, base} + (CNT_W+1)'(len) + {{CNT_W{1'b0}}, margin};
      return ((pos_w + {{CNT_W{1'b0}}, margin}) >= lo_w) && (pos_w < hi_w);
   endfunction

endpackage

// File: rtl/draw_missile_pool_if.sv
// Bus bundle between the VGA draw chain / game logic and the missile pool.
interface draw_missile_pool_if #(
   parameter int N = 4
);
   import draw_missile_pool_pkg::*;

   // Game-side control
   logic          fire;
   logic          fire_ready;
   vga_cnt_t      ship_xpos;
   vga_cnt_t      ship_ypos;
   logic [N-1:0]  kill;
   logic [N-1:0]  active;

   // Upstream VGA stream
   vga_cnt_t      hcount_in;
   logic          hsync_in;
   logic          hblnk_in;
   vga_cnt_t      vcount_in;
   logic          vsync_in;
   logic          vblnk_in;
   rgb_t          rgb_in;

   // Downstream VGA stream
   vga_cnt_t      hcount_out;
   logic          hsync_out;
   logic          hblnk_out;
   vga_cnt_t      vcount_out;
   logic          vsync_out;
   logic          vblnk_out;
   rgb_t          rgb_out;

   // Driver side: game logic plus upstream draw stage.
   modport master (
      output fire, ship_xpos, ship_ypos, kill,
      output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
      input  fire_ready, active,
      input  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out
   );

   // The missile pool itself.
   modport slave (
      input  fire, ship_xpos, ship_ypos, kill,
      input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
      output fire_ready, active,
      output hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out
   );

endinterface

// File: rtl/draw_missile_pool_slot.sv
// One missile slot: live flag and position, kill > move > spawn update,
// and the per-pixel rectangle (and optional halo, MISSILE_POOL_GLOW_EN) test.
module draw_missile_pool_slot
   import draw_missile_pool_pkg::*;
#(
   parameter int WIDTH_RECT  = 5,
   parameter int HEIGHT_RECT = 20,
   parameter int SPEED       = 4
) (
   input  logic     pclk,
   input  logic     rst,
   input  logic     tick_i,
   input  logic     kill_i,
   input  logic     spawn_i,
   input  vga_cnt_t spawn_x_i,
   input  vga_cnt_t spawn_y_i,
   input  vga_cnt_t hcount_i,
   input  vga_cnt_t vcount_i,
   output logic     active_o,
`ifdef MISSILE_POOL_GLOW_EN
   output logic     glow_hit_o,
`endif
   output logic     hit_o
);

   logic     active_q, active_d;
   vga_cnt_t x_q, x_d;
   vga_cnt_t y_q, y_d;

   // Next state: a live slot only reacts to kill/move; spawn is only ever
   // steered to a slot that was free at cycle start, so it cannot collide.
   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      if (active_q) begin
         if (kill_i) begin
            active_d = 1'b0;
         end else if (tick_i) begin
            if (y_q < CNT_W'(SPEED)) begin
               active_d = 1'b0;           // would cross the top: retire, never wrap
            end else begin
               y_d = y_q - CNT_W'(SPEED);
            end
         end
      end else if (spawn_i) begin
         active_d = 1'b1;
         x_d      = spawn_x_i;
         y_d      = spawn_y_i;
      end
   end

   // Slot state register.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

   assign active_o = active_q;

   // Core rectangle test for the pixel currently on the bus.
   always_comb begin
      hit_o = active_q
            & span_hit(hcount_i, x_q, WIDTH_RECT, 1'b0)
            & span_hit(vcount_i, y_q, HEIGHT_RECT, 1'b0);
   end

`ifdef MISSILE_POOL_GLOW_EN
   // Halo: the one-pixel ring just outside the core rectangle.
   always_comb begin
      glow_hit_o = active_q
                 & span_hit(hcount_i, x_q, WIDTH_RECT, 1'b1)
                 & span_hit(vcount_i, y_q, HEIGHT_RECT, 1'b1)
                 & ~hit_o;
   end
`endif

endmodule

// File: rtl/draw_missile_pool.sv
// Player missile pool: fire allocation, per-frame climb, cooldown and
// overlay of all live missiles on the VGA stream (1 pclk latency).
// Optional halo drawing enabled by defining MISSILE_POOL_GLOW_EN.
module draw_missile_pool
   import draw_missile_pool_pkg::*;
#(
   parameter int   N_MISSILES  = 4,
   parameter int   WIDTH_RECT  = 5,
   parameter int   HEIGHT_RECT = 20,
   parameter int   X_OFFSET    = 21,
   parameter int   SPEED       = 4,
   parameter int   COOLDOWN    = 8,
   parameter rgb_t COLOR       = MISSILE_COLOR
) (
   input  logic                 pclk,
   input  logic                 rst,
   draw_missile_pool_if.slave   bus
);

   localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   logic                  vsync_q;
   logic                  tick;
   logic [CD_W-1:0]       cooldown_q, cooldown_d;
   logic [N_MISSILES-1:0] active_vec;
   logic [N_MISSILES-1:0] hit_vec;
   logic [N_MISSILES-1:0] spawn_vec;
   logic                  fire_ready;
   logic                  fire_acc;
   vga_cnt_t              spawn_x;
   vga_cnt_t              spawn_y;
   vga_timing_t           timing_q, timing_d;
   rgb_t                  rgb_q, rgb_d;
`ifdef MISSILE_POOL_GLOW_EN
   logic [N_MISSILES-1:0] glow_vec;
`endif

   // Remember last vsync so its rising edge becomes a one-cycle frame tick.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         vsync_q <= 1'b0;
      end else begin
         vsync_q <= bus.vsync_in;
      end
   end

   assign tick = bus.vsync_in & ~vsync_q;

   // Shots are gated by a free slot and an expired cooldown; forced low in reset.
   assign fire_ready     = rst & ~(&active_vec) & (cooldown_q == '0);
   assign fire_acc       = bus.fire & fire_ready;
   assign bus.fire_ready = fire_ready;
   assign bus.active     = active_vec;

   // Spawn position: centred over the ship, clamped at the top of the screen.
   always_comb begin
      spawn_x = bus.ship_xpos + CNT_W'(X_OFFSET);
      if (bus.ship_ypos < CNT_W'(HEIGHT_RECT)) begin
         spawn_y = '0;
      end else begin
         spawn_y = bus.ship_ypos - CNT_W'(HEIGHT_RECT);
      end
   end

   // Lowest-index free slot receives the accepted shot.
   always_comb begin
      logic found;
      spawn_vec = '0;
      found     = 1'b0;
      for (int i = 0; i < N_MISSILES; i++) begin
         if (!active_vec[i] && !found) begin
            spawn_vec[i] = fire_acc;
            found        = 1'b1;
         end
      end
   end

   // Cooldown: a fresh shot reloads it even on a tick cycle; else count down per frame.
   always_comb begin
      cooldown_d = cooldown_q;
      if (fire_acc) begin
         cooldown_d = CD_W'(COOLDOWN);
      end else if (tick && (cooldown_q != '0)) begin
         cooldown_d = cooldown_q - CD_W'(1);
      end
   end

   // Cooldown register.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         cooldown_q <= '0;
      end else begin
         cooldown_q <= cooldown_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_MISSILES; gi++) begin : g_slot
         draw_missile_pool_slot #(
            .WIDTH_RECT  (WIDTH_RECT),
            .HEIGHT_RECT (HEIGHT_RECT),
            .SPEED       (SPEED)
         ) u_slot (
            .pclk        (pclk),
            .rst         (rst),
            .tick_i      (tick),
            .kill_i      (bus.kill[gi]),
            .spawn_i     (spawn_vec[gi]),
            .spawn_x_i   (spawn_x),
            .spawn_y_i   (spawn_y),
            .hcount_i    (bus.hcount_in),
            .vcount_i    (bus.vcount_in),
            .active_o    (active_vec[gi]),
`ifdef MISSILE_POOL_GLOW_EN
            .glow_hit_o  (glow_vec[gi]),
`endif
            .hit_o       (hit_vec[gi])
         );
      end
   endgenerate

   // Pixel compose: blanking, then missile core, then halo, then upstream.
   always_comb begin
      timing_d = '{hcount: bus.hcount_in, hsync: bus.hsync_in, hblnk: bus.hblnk_in,
                   vcount: bus.vcount_in, vsync: bus.vsync_in, vblnk: bus.vblnk_in};
      rgb_d = bus.rgb_in;
      if (bus.hblnk_in || bus.vblnk_in) begin
         rgb_d = '0;
      end else if (|hit_vec) begin
         rgb_d = COLOR;
`ifdef MISSILE_POOL_GLOW_EN
      end else if (|glow_vec) begin
         rgb_d = GLOW_COLOR;
`endif
      end
   end

   // Output register keeps pixel and timing aligned at one pclk latency.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         timing_q <= '0;
         rgb_q    <= '0;
      end else begin
         timing_q <= timing_d;
         rgb_q    <= rgb_d;
      end
   end

   assign bus.hcount_out = timing_q.hcount;
   assign bus.hsync_out  = timing_q.hsync;
   assign bus.hblnk_out  = timing_q.hblnk;
   assign bus.vcount_out = timing_q.vcount;
   assign bus.vsync_out  = timing_q.vsync;
   assign bus.vblnk_out  = timing_q.vblnk;
   assign bus.rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_missile_pool.sv
// Bench for draw_missile_pool: a rectangle-level model checked every cycle,
// plus literal expectations at the directed scenarios.
module tb_draw_missile_pool;

   localparam int N   = 4;
   localparam int W   = 5;
   localparam int H   = 20;
   localparam int XO  = 21;
   localparam int SPD = 4;
   localparam int CD  = 8;
   localparam logic [11:0] COL = 12'hDD3;
   localparam logic [11:0] BG  = 12'h0A5;
`ifdef MISSILE_POOL_GLOW_EN
   localparam logic [11:0] GLOWEXP = 12'h862;
`else
   localparam logic [11:0] GLOWEXP = BG;
`endif

   logic pclk;
   logic rst;

   draw_missile_pool_if #(.N(N)) bus();

   draw_missile_pool #(
      .N_MISSILES (N), .WIDTH_RECT (W), .HEIGHT_RECT (H),
      .X_OFFSET (XO), .SPEED (SPD), .COOLDOWN (CD), .COLOR (COL)
   ) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // ---------------- model state ----------------
   bit          m_act [N];
   int          m_x   [N];
   int          m_y   [N];
   int          m_cd;
   bit          m_vs;
   logic [11:0] e_rgb;
   logic [25:0] e_tim;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   function automatic logic [N-1:0] m_active_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_act[i];
      return v;
   endfunction

   function automatic bit m_full();
      bit f = 1'b1;
      for (int i = 0; i < N; i++) if (!m_act[i]) f = 1'b0;
      return f;
   endfunction

   // What the pixel must be, given the live missile rectangles.
   function automatic logic [11:0] m_pix(input int h, input int v, input logic [11:0] rin, input bit blank);
      bit core = 1'b0;
      bit halo = 1'b0;
      if (blank) return 12'h000;
      for (int i = 0; i < N; i++) begin
         if (m_act[i]) begin
            if (h >= m_x[i] && h <= m_x[i] + W - 1 && v >= m_y[i] && v <= m_y[i] + H - 1)
               core = 1'b1;
            else if (h >= m_x[i] - 1 && h <= m_x[i] + W && v >= m_y[i] - 1 && v <= m_y[i] + H)
               halo = 1'b1;
         end
      end
      if (core) return COL;
`ifdef MISSILE_POOL_GLOW_EN
      if (halo) return 12'h862;
`endif
      return rin;
   endfunction

   task automatic model_step();
      bit tick, acc;
      int free_idx;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
         end
         m_cd  = 0;
         m_vs  = 1'b0;
         e_rgb = '0;
         e_tim = '0;
         return;
      end
      tick  = bus.vsync_in && !m_vs;
      acc   = bus.fire && !m_full() && (m_cd == 0);
      e_rgb = m_pix(int'(bus.hcount_in), int'(bus.vcount_in), bus.rgb_in,
                    bus.hblnk_in || bus.vblnk_in);
      e_tim = {bus.hcount_in, bus.hsync_in, bus.hblnk_in, bus.vcount_in, bus.vsync_in, bus.vblnk_in};
      free_idx = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) free_idx = i;
      for (int i = 0; i < N; i++) begin
         if (m_act[i]) begin
            if (bus.kill[i]) m_act[i] = 1'b0;
            else if (tick) begin
               if (m_y[i] < SPD) m_act[i] = 1'b0;
               else m_y[i] = m_y[i] - SPD;
            end
         end
      end
      if (acc && free_idx >= 0) begin
         m_act[free_idx] = 1'b1;
         m_x[free_idx]   = (int'(bus.ship_xpos) + XO) % 2048;
         m_y[free_idx]   = (int'(bus.ship_ypos) < H) ? 0 : int'(bus.ship_ypos) - H;
      end
      if (acc) m_cd = CD;
      else if (tick && m_cd > 0) m_cd = m_cd - 1;
      m_vs = bus.vsync_in;
   endtask

   initial begin
      forever begin
         @(posedge pclk or negedge rst);
         model_step();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge pclk);
         if (cmp_en) begin
            chk("active", 32'(bus.active), 32'(m_active_vec()));
            chk("fire_ready", 32'(bus.fire_ready), 32'(rst && !m_full() && m_cd == 0));
            chk("rgb_out", 32'(bus.rgb_out), 32'(e_rgb));
            chk("timing", 32'({bus.hcount_out, bus.hsync_out, bus.hblnk_out,
                               bus.vcount_out, bus.vsync_out, bus.vblnk_out}), 32'(e_tim));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic tick_frame();
      bus.vsync_in = 1'b1; cyc();
      bus.vsync_in = 1'b0; cyc();
   endtask

   task automatic do_reset();
      rst = 1'b0; cyc(); cyc();
      rst = 1'b1; cyc();
   endtask

   task automatic pix_chk(input string name, input int h, input int v, input logic [11:0] exp);
      bus.hcount_in = 11'(h);
      bus.vcount_in = 11'(v);
      cyc();
      chk(name, 32'(bus.rgb_out), 32'(exp));
      $display("txn pixel %s (%0d,%0d) rgb=%h", name, h, v, bus.rgb_out);
   endtask

   task automatic fire_once();
      bus.fire = 1'b1; cyc();
      bus.fire = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      bus.fire = 1'b0; bus.ship_xpos = 11'd100; bus.ship_ypos = 11'd400; bus.kill = '0;
      bus.hcount_in = '0; bus.hsync_in = 1'b0; bus.hblnk_in = 1'b0;
      bus.vcount_in = '0; bus.vsync_in = 1'b0; bus.vblnk_in = 1'b0;
      bus.rgb_in = BG;
      cyc();
      cmp_en = 1'b1;

      // Reset state
      chk("rst_active", 32'(bus.active), 32'h0);
      chk("rst_rgb", 32'(bus.rgb_out), 32'h0);
      chk("rst_ready", 32'(bus.fire_ready), 32'h0);
      cyc(); rst = 1'b1; cyc();
      $display("txn reset released active=%b ready=%b", bus.active, bus.fire_ready);

      // Single shot from (100,400)
      fire_once();
      chk("spawn_active", 32'(bus.active), 32'h1);
      $display("txn fire active=%b", bus.active);
      pix_chk("core_tl", 121, 380, COL);
      pix_chk("core_br", 125, 399, COL);
      pix_chk("right_of", 126, 380, GLOWEXP);
      pix_chk("right_far", 127, 380, BG);
      pix_chk("below", 121, 401, BG);
      pix_chk("left_halo", 120, 380, GLOWEXP);
      bus.hblnk_in = 1'b1;
      pix_chk("blank", 121, 380, 12'h000);
      bus.hblnk_in = 1'b0;

      // Hold fire: one shot per 8 frames until all slots live
      bus.fire = 1'b1;
      for (int f = 1; f <= 30; f++) begin
         tick_frame();
         if (f == 16) chk("hold_f16", 32'(bus.active), 32'h7);
      end
      chk("hold_full", 32'(bus.active), 32'hF);
      chk("hold_ready", 32'(bus.fire_ready), 32'h0);
      $display("txn hold-fire active=%b ready=%b", bus.active, bus.fire_ready);
      bus.fire = 1'b0;

      // Mid-frame reset with live missiles
      bus.hcount_in = 11'd300;
      rst = 1'b0; cyc();
      chk("midrst_active", 32'(bus.active), 32'h0);
      chk("midrst_rgb", 32'(bus.rgb_out), 32'h0);
      chk("midrst_ready", 32'(bus.fire_ready), 32'h0);
      cyc(); rst = 1'b1; cyc();
      pix_chk("after_rst", 121, 260, BG);
      $display("txn mid-frame reset active=%b", bus.active);

      // Retire at top: y=3, one tick
      bus.ship_ypos = 11'd23;
      fire_once();
      chk("y3_active", 32'(bus.active), 32'h1);
      pix_chk("y3_core", 121, 3, COL);
      tick_frame();
      chk("retired", 32'(bus.active), 32'h0);
      pix_chk("no_wrap", 121, 2047, BG);
      $display("txn retire active=%b", bus.active);

      // kill > move > spawn in one cycle
      do_reset();
      bus.ship_ypos = 11'd400;
      fire_once();
      for (int f = 0; f < 8; f++) tick_frame();
      fire_once();
      chk("two_live", 32'(bus.active), 32'h3);
      bus.kill = 4'b0001; cyc(); bus.kill = '0;
      chk("kill0", 32'(bus.active), 32'h2);
      for (int f = 0; f < 8; f++) tick_frame();
      bus.vsync_in = 1'b1; bus.kill = 4'b0010; bus.fire = 1'b1; cyc();
      bus.vsync_in = 1'b0; bus.kill = '0;      bus.fire = 1'b0;
      chk("kill_tick_fire", 32'(bus.active), 32'h1);
      bus.kill = 4'b1000; cyc(); bus.kill = '0;
      chk("kill_inactive", 32'(bus.active), 32'h1);
      pix_chk("fresh_unmoved", 121, 380, COL);
      $display("txn kill/tick/fire active=%b", bus.active);

      // Top clamp
      do_reset();
      bus.ship_xpos = 11'd200; bus.ship_ypos = 11'd10;
      fire_once();
      pix_chk("clamp_core", 221, 0, COL);
      pix_chk("clamp_halo", 220, 0, GLOWEXP);
      pix_chk("clamp_bot", 221, 19, COL);
      pix_chk("clamp_below", 221, 20, GLOWEXP);
      pix_chk("clamp_far", 221, 21, BG);

      // Right screen edge: rectangle 2046..2050 must not wrap to column 0
      do_reset();
      bus.ship_xpos = 11'd2025; bus.ship_ypos = 11'd100;
      fire_once();
      pix_chk("edge_core", 2047, 80, COL);
      pix_chk("edge_wrap", 0, 80, BG);
      pix_chk("edge_halo", 2045, 80, GLOWEXP);
      bus.vblnk_in = 1'b1;
      pix_chk("edge_vblank", 2047, 80, 12'h000);
      bus.vblnk_in = 1'b0;
      cyc(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
